// File: rtl/tinyodin_neuron_mem_arbiter.sv
// tinyODIN neuron state SRAM arbiter.
// Core has priority; bounded host wait; core read-modify-write lock.
module tinyodin_neuron_mem_arbiter #(
   parameter int M             = 8,
   parameter int DW            = 32,
   parameter int HOST_MAX_WAIT = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            core_req_i,
   input  logic            core_we_i,
   input  logic            core_lock_i,
   input  logic [M-1:0]    core_addr_i,
   input  logic [DW-1:0]   core_wdata_i,
   output logic            core_gnt_o,
   output logic            core_rvalid_o,
   output logic [DW-1:0]   core_rdata_o,
   input  logic            host_req_i,
   input  logic            host_we_i,
   input  logic [DW/8-1:0] host_be_i,
   input  logic [M-1:0]    host_addr_i,
   input  logic [DW-1:0]   host_wdata_i,
   output logic            host_gnt_o,
   output logic            host_rvalid_o,
   output logic [DW-1:0]   host_rdata_o,
   output logic            mem_cs_o,
   output logic            mem_we_o,
   output logic [DW-1:0]   mem_wmask_o,
   output logic [M-1:0]    mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic [DW-1:0]   mem_rdata_i
);

   localparam int WW = $clog2(HOST_MAX_WAIT + 1);
   localparam logic [WW-1:0] WMAX = WW'(HOST_MAX_WAIT);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            rd_core_q, rd_host_q, wr_host_q;
   logic            core_g, host_g;
   logic [DW-1:0]   host_mask;

   // Expand host byte enables into a bit mask
   always_comb begin
      host_mask = '0;
      for (int b = 0; b < DW/8; b++) begin
         host_mask[b*8 +: 8] = {8{host_be_i[b]}};
      end
   end

   // Arbitration, lock tracking and host wait counter
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      core_g  = 1'b0;
      host_g  = 1'b0;
      if (!RST) begin
         case (state_q)
            IDLE: begin
               host_g = host_req_i &&
                        (!core_req_i || wait_q == WMAX);
               core_g = core_req_i && !host_g;
               if (host_g) begin
                  wait_d = '0;
               end else if (host_req_i && wait_q != WMAX) begin
                  wait_d = wait_q + 1'b1;
               end
               if (core_g && !core_we_i && core_lock_i) begin
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               core_g = core_req_i;
               if ((core_g && core_we_i) || !core_lock_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Drive the SRAM from whichever requester holds the grant
   always_comb begin
      mem_cs_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_wmask_o = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (core_g) begin
         mem_cs_o    = 1'b1;
         mem_we_o    = core_we_i;
         mem_wmask_o = core_we_i ? '1 : '0;
         mem_addr_o  = core_addr_i;
         mem_wdata_o = core_wdata_i;
      end else if (host_g) begin
         mem_cs_o    = 1'b1;
         mem_we_o    = host_we_i;
         mem_wmask_o = host_we_i ? host_mask : '0;
         mem_addr_o  = host_addr_i;
         mem_wdata_o = host_wdata_i;
      end
   end

   // State, wait counter and response-type flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         rd_core_q <= 1'b0;
         rd_host_q <= 1'b0;
         wr_host_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         rd_core_q <= core_g & ~core_we_i;
         rd_host_q <= host_g & ~host_we_i;
         wr_host_q <= host_g & host_we_i;
      end
   end

   // Responses are suppressed while reset is asserted
   always_comb begin
      core_gnt_o    = core_g;
      host_gnt_o    = host_g;
      core_rvalid_o = rd_core_q & ~RST;
      core_rdata_o  = (rd_core_q & ~RST) ? mem_rdata_i : '0;
      host_rvalid_o = (rd_host_q | wr_host_q) & ~RST;
      host_rdata_o  = (rd_host_q & ~RST) ? mem_rdata_i : '0;
   end

endmodule

// File: doc/tinyodin_neuron_mem_arbiter.md
# tinyodin_neuron_mem_arbiter

Single-port arbiter for the tinyODIN neuron state SRAM. It shares the SRAM between two requesters: the core update path (the time-multiplexed charge, neuron-event and refractory sweeps) and a host OBI slave used for neuron configuration and readback. Core requests have priority. A bounded-wait counter guarantees host progress, and a lock keeps core read-modify-write pairs atomic.

## Interface
Parameters:
- M, 8, neuron address width (N = 2^M neurons)
- DW, 32, neuron state word width
- HOST_MAX_WAIT, 16, maximum number of stalled host-request cycles before the host is forced through; must be ≥1

Ports:
- CLK  in  1  clock
- RST  in  1  reset: synchronous, active-high
- core_req_i  in  1  core access request
- core_we_i  in  1  core write (1) / read (0)
- core_lock_i  in  1  with a core read, holds the port for the following core write
- core_addr_i  in  M  neuron index
- core_wdata_i  in  DW  core write data
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  DW  core read data
- host_req_i  in  1  OBI req
- host_we_i  in  1  OBI we
- host_be_i  in  DW/8  OBI byte enables
- host_addr_i  in  M  word (neuron) index
- host_wdata_i  in  DW  OBI wdata
- host_gnt_o  out  1  OBI gnt
- host_rvalid_o  out  1  OBI rvalid, for reads and writes
- host_rdata_o  out  DW  OBI rdata; 0 for writes
- mem_cs_o  out  1  SRAM chip select
- mem_we_o  out  1  SRAM write enable
- mem_wmask_o  out  DW  SRAM bit write mask
- mem_addr_o  out  M  SRAM address
- mem_wdata_o  out  DW  SRAM write data
- mem_rdata_i  in  DW  SRAM read data, valid one cycle after a read cs

## Operation
- FSM states:
  - IDLE: normal arbitration.
  - LOCKED: the core owns the port.
- IDLE arbitration, at most one grant per cycle:
  - Host only: grant the host.
  - Core only: grant the core.
  - Both, with wait_cnt < HOST_MAX_WAIT: grant the core.
  - Both, with wait_cnt == HOST_MAX_WAIT: grant the host; the core stalls.
- IDLE → LOCKED on a granted core read with core_lock_i=1.
- LOCKED:
  - The host is never granted, and wait_cnt is frozen.
  - The core is granted whenever core_req_i=1.
  - LOCKED → IDLE on a granted core write, or in any cycle where core_lock_i=0. In the exit cycle the host remains blocked.
- wait_cnt (width clog2(HOST_MAX_WAIT+1)):
  - Increments in IDLE when host_req_i=1 and the host is not granted.
  - Clears on a host grant.
  - Saturates at HOST_MAX_WAIT.
- Memory drive: the granted requester drives mem_addr_o, mem_wdata_o and mem_we_o, with mem_cs_o=1.
  - Core write: mem_wmask_o is all ones.
  - Host write: each bit of mem_wmask_o is the byte-enable of its byte (host_be_i expanded per byte).
  - No grant: mem_cs_o=0, and all other mem outputs are 0.
- Response tracking: registered flags rd_core, rd_host and wr_host record the grant type.
- Combinational paths: grants and mem_* are combinational from the requests and the state. There is no request-to-grant path through the rdata side.

## Timing
- Grant is in the same cycle as the request.
- Read data:
  - Core: core_rvalid_o=1 exactly one cycle after a granted core read, with core_rdata_o=mem_rdata_i.
  - Host: host_rvalid_o=1 exactly one cycle after a granted host read, with host_rdata_o=mem_rdata_i.
  - Otherwise the rdata outputs are 0.
- Host writes: host_rvalid_o=1 one cycle after the grant, with host_rdata_o=0. Core writes produce no rvalid.
- Throughput: back-to-back grants are allowed every cycle, alternating requesters included.
- RST=1:
  - All outputs are forced to 0 in that cycle.
  - The state goes to IDLE, wait_cnt to 0, and all response flags to 0.
  - Reset mid-operation: a read granted in the cycle before RST produces no rvalid.
- Host forced-grant worst case: a continuously requesting host is granted within HOST_MAX_WAIT+1 IDLE cycles of its first request. LOCKED cycles are not counted.
- Collision: if a core read-lock and a host force coincide, the host wins. The core retries, and the lock is taken only on the core grant.

## Test plan
- Reset: hold RST 3 cycles with both requesters active → all outputs 0; first cycle after release, core granted.
- Host-only read, addr 0x12, SRAM word 0xDEADBEEF → host_gnt_o same cycle; host_rvalid_o next cycle with 0xDEADBEEF. Host-only write: be=4'b0101 → mem_wmask_o=0x00FF00FF; host_rvalid_o next cycle with rdata 0.
- Starvation: core requests every cycle, host requests continuously, HOST_MAX_WAIT=16 → 16 core grants, host granted on cycle 17 while core_gnt_o=0; wait_cnt back to 0.
- Lock: core read with lock at addr 5, host requesting, then core write addr 5 two cycles later → host_gnt_o stays 0 through the write cycle; host granted the following cycle; wait_cnt unchanged across LOCKED.
- Lock release: core_lock_i drops without a write → return to IDLE; host granted next cycle if the core is idle.
- Reset mid-read: grant a host read, assert RST next cycle → host_rvalid_o stays 0; state IDLE after release.
